// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : Program-counter sequencer between fetch and execute. Advances
//               the PC by 2 per fetch, applies resolved redirects from execute,
//               squashes wrong-path instructions for FLUSH_DEPTH cycles, and
//               handles stalls, HALT and misaligned-target errors.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt_ex,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc_out,
    output logic [15:0] inc_pc,
    output logic        fetch_en,
    output logic        flush,
    output logic        halted,
    output logic        err
);

    // State encodings
    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_FLUSH  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;
    localparam logic [1:0] c_ST_ERR    = 2'd3;

    typedef enum logic [1:0] {
        RUN    = c_ST_RUN,
        FLUSH  = c_ST_FLUSH,
        HALTED = c_ST_HALTED,
        ERR    = c_ST_ERR
    } state_t;

    localparam logic [2:0] c_FLUSH_INIT = 3'(FLUSH_DEPTH);

    state_t      r_state_q;
    state_t      w_state_d;
    logic [15:0] r_pc_q;
    logic [15:0] w_pc_d;
    logic [2:0]  r_cnt_q;
    logic [2:0]  w_cnt_d;
    logic [15:0] w_inc_pc;

    // Sequential PC increment; carry out of bit 15 is intentionally dropped
    assign w_inc_pc = r_pc_q + 16'd2;

    // Next-state, next-PC and flush-counter selection
    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            RUN: begin
                if (halt_ex) begin
                    // HALT wins over redirect and stall; PC freezes
                    w_state_d = HALTED;
                end else if (redirect_valid && redirect_pc[0]) begin
                    w_state_d = ERR;
                end else if (redirect_valid) begin
                    // Redirect overrides a concurrent stall
                    w_pc_d    = redirect_pc;
                    w_cnt_d   = c_FLUSH_INIT;
                    w_state_d = FLUSH;
                end else if (!stall) begin
                    w_pc_d = w_inc_pc;
                end
            end
            FLUSH: begin
                // Redirect/halt here come from squashed instructions: ignored
                if (!stall) begin
                    w_pc_d  = w_inc_pc;
                    w_cnt_d = r_cnt_q - 3'd1;
                    if (r_cnt_q == 3'd1) begin
                        w_state_d = RUN;
                    end
                end
            end
            default: begin
                // HALTED and ERR are terminal until reset
            end
        endcase
    end

    // State, PC and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= RUN;
            r_pc_q    <= RESET_PC;
            r_cnt_q   <= 3'd0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign pc_out   = r_pc_q;
    assign inc_pc   = w_inc_pc;
    assign flush    = (r_state_q == FLUSH);
    assign halted   = (r_state_q == HALTED) || (r_state_q == ERR);
    assign err      = (r_state_q == ERR);
    assign fetch_en = ((r_state_q == RUN) || (r_state_q == FLUSH)) && !stall && rst_n;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_ctrl
// Description : Self-checking bench for pc_redirect_ctrl. Each vector is one
//               clock cycle: inputs driven after the falling edge, outputs of
//               that same cycle compared shortly afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_ctrl;

    typedef struct packed {
        logic        rst_n;
        logic        stall;
        logic        halt;
        logic        rv;
        logic [15:0] rpc;
        logic [15:0] pc;
        logic [15:0] inc;
        logic        fe;
        logic        fl;
        logic        hl;
        logic        er;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        halt_ex = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] pc_out;
    logic [15:0] inc_pc;
    logic        fetch_en;
    logic        flush;
    logic        halted;
    logic        err;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    vec_t sb[$];

    pc_redirect_ctrl #(
        .RESET_PC    (16'h0000),
        .FLUSH_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .halt_ex        (halt_ex),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_out         (pc_out),
        .inc_pc         (inc_pc),
        .fetch_en       (fetch_en),
        .flush          (flush),
        .halted         (halted),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic h,
                                input logic v, input logic [15:0] rp,
                                input logic [15:0] pc, input logic [15:0] inc,
                                input logic fe, input logic fl,
                                input logic hl, input logic er);
        vec_t t;
        t.rst_n = r;  t.stall = s; t.halt = h; t.rv = v; t.rpc = rp;
        t.pc = pc;    t.inc = inc; t.fe = fe;  t.fl = fl; t.hl = hl; t.er = er;
        return t;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst_n          = v.rst_n;
        stall          = v.stall;
        halt_ex        = v.halt;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        check("pc_out",   idx, pc_out,          e.pc);
        check("inc_pc",   idx, inc_pc,          e.inc);
        check("fetch_en", idx, {15'd0, fetch_en}, {15'd0, e.fe});
        check("flush",    idx, {15'd0, flush},    {15'd0, e.fl});
        check("halted",   idx, {15'd0, halted},   {15'd0, e.hl});
        check("err",      idx, {15'd0, err},      {15'd0, e.er});
    endtask

    initial begin
        //                  rst stl hlt rv  rpc       | pc        inc      fe fl hl er
        // reset, release, free-running increment
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0004, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h0006, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0006, 16'h0008, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0008, 16'h000A, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h000A, 16'h000C, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h000C, 16'h000E, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h000E, 16'h0010, 1, 0, 0, 0));
        // redirect to 0040, two flush cycles, back to RUN
        vecs.push_back(mk(1, 0, 0, 1, 16'h0040, 16'h0010, 16'h0012, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0040, 16'h0042, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0042, 16'h0044, 1, 1, 0, 0));
        // redirect to 0080, stall 3 cycles inside FLUSH
        vecs.push_back(mk(1, 0, 0, 1, 16'h0080, 16'h0044, 16'h0046, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h0080, 16'h0082, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h0080, 16'h0082, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h0080, 16'h0082, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0080, 16'h0082, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0082, 16'h0084, 1, 1, 0, 0));
        // stall in RUN, then redirect overriding a stall
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h0084, 16'h0086, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 16'h001C, 16'h0084, 16'h0086, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h001C, 16'h001E, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h001E, 16'h0020, 1, 1, 0, 0));
        // halt + redirect + stall together at 0020
        vecs.push_back(mk(1, 1, 1, 1, 16'h0040, 16'h0020, 16'h0022, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0040, 16'h0020, 16'h0022, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0020, 16'h0022, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0020, 16'h0022, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0, 0));
        // misaligned target at 0008
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0004, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h0006, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0006, 16'h0008, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0031, 16'h0008, 16'h000A, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0050, 16'h0008, 16'h000A, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0008, 16'h000A, 0, 0, 1, 1));
        // wrap at FFFE; redirect and halt during FLUSH are ignored
        vecs.push_back(mk(1, 0, 0, 1, 16'hFFFA, 16'h0000, 16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0100, 16'hFFFA, 16'hFFFC, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 16'h0000, 16'hFFFC, 16'hFFFE, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'hFFFE, 16'h0000, 1, 0, 0, 0));
        // reset in the middle of FLUSH
        vecs.push_back(mk(1, 0, 0, 1, 16'h0200, 16'h0000, 16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0200, 16'h0202, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0, 0));

        // Two reset edges before any comparison
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) apply(vecs[i], i);

        // Hand-written: misaligned redirect under stall still reaches ERR,
        // then a single reset edge fully recovers
        apply(mk(1, 1, 0, 1, 16'h0003, 16'h0002, 16'h0004, 0, 0, 0, 0), 100);
        apply(mk(1, 1, 0, 0, 16'h0000, 16'h0002, 16'h0004, 0, 0, 1, 1), 101);
        apply(mk(0, 0, 0, 0, 16'h0000, 16'h0002, 16'h0004, 0, 0, 1, 1), 102);
        apply(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0, 0), 103);
        apply(mk(1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0004, 1, 0, 0, 0), 104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Sequences the program counter around the execute stage. Owns the PC register and advances it by 2 each fetch. It accepts the resolved next-PC and taken indication from execute (branch, jump, JR/JALR), and on a redirect squashes the wrong-path instructions already fetched. It also handles hazard stalls, HALT and misaligned-target errors, and sits between fetch and execute in the pipelined processor.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
FLUSH_DEPTH, 2, cycles of flush asserted after a redirect; legal 1..7.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
stall  input  1  hazard stall from the pipeline; hold the PC.
halt_ex  input  1  HALT instruction valid in execute.
redirect_valid  input  1  execute resolved a taken branch or jump this cycle.
redirect_pc  input  16  target PC from execute (the newPC value).
pc_out  output  16  current fetch PC (registered).
inc_pc  output  16  pc_out + 2, combinational, wraps modulo 2^16.
fetch_en  output  1  instruction memory read enable.
flush  output  1  squash the IF/ID and ID/EX pipeline registers.
halted  output  1  sticky; the processor has halted.
err  output  1  sticky; a misaligned redirect target was seen.

Behaviour:
- States: RUN, FLUSH, HALTED, ERR. Each state is encoded in a register.
- Reset, sampled while rst_n=0 at a clk edge:
  - state=RUN, pc_out=RESET_PC, flush counter=0.
  - flush=0, halted=0, err=0.
  - fetch_en is forced to 0 combinationally while rst_n=0.
- fetch_en = (state==RUN or state==FLUSH) and !stall and rst_n.
- inc_pc = pc_out+2 with carry dropped, so 16'hFFFE gives 16'h0000.
- RUN, event priority, highest first:
  1. halt_ex=1: go to HALTED. The PC holds. This wins over a simultaneous redirect_valid or stall.
  2. redirect_valid=1 and redirect_pc[0]=1: go to ERR. The PC holds.
  3. redirect_valid=1 and the target is aligned:
     - pc_out<=redirect_pc and counter<=FLUSH_DEPTH; go to FLUSH.
     - A redirect takes effect even when stall=1, because the redirect overrides the stall.
  4. stall=1: the PC holds.
  5. Otherwise: pc_out<=inc_pc.
- FLUSH:
  - flush=1 (a state decode) for as long as the state is FLUSH.
  - Each non-stalled cycle: pc_out<=inc_pc and the counter decrements.
  - Stalled cycle: the PC and counter hold, and flush stays at 1.
  - When the counter reaches 1 and the cycle is not stalled, return to RUN next edge.
  - redirect_valid and halt_ex are ignored in FLUSH, because they come from squashed wrong-path instructions.
  - Net effect: flush is high for exactly FLUSH_DEPTH non-stalled cycles.
- HALTED:
  - halted=1 and fetch_en=0; pc_out is frozen.
  - All inputs are ignored; the only exit is reset.
- ERR:
  - err=1 and halted=1, fetch_en=0; pc_out is frozen at its pre-redirect value.
  - The only exit is reset.
- Latency: a redirect asserted in cycle N appears on pc_out in cycle N+1, with flush high from N+1.
- Reset mid-FLUSH or mid-HALTED returns to the reset state on the next edge; no residual flush.
- All outputs except inc_pc and fetch_en come straight from registers or a decode of the state register.

Test Plan:
- Reset release with RESET_PC=0 and no stimulus for 4 cycles -> pc_out 0000, 0002, 0004, 0006; fetch_en=1; flush=0.
- Redirect with pc_out=0010: redirect_valid=1 with redirect_pc=0040 for one cycle ->
  - next cycle pc_out=0040 and flush=1 for 2 cycles, while pc_out steps 0040, 0042;
  - then RUN at 0044 with flush=0.
- stall=1 for 3 cycles during FLUSH -> pc_out and flush hold; after the stall releases, flush stays high for the remaining count.
- halt_ex=1 and redirect_valid=1 in the same cycle with pc_out=0020 -> HALTED, pc_out stays 0020, fetch_en=0, halted=1; later redirects are ignored.
- redirect_pc=0031 with pc_out=0008 -> err=1, halted=1, pc_out stays 0008. Then rst_n=0 for one edge -> all outputs return to their reset values.
- pc_out=FFFE in RUN -> inc_pc=0000 and next pc_out=0000. A redirect during FLUSH (to 0100) is ignored and pc_out keeps incrementing.
